// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB FS endpoint packet buffers (IN and OUT).
// Holds the buffer state encoding and the DATA0/DATA1 PID toggle values.
package usb_ep_pkg;

   typedef enum logic [1:0] {
      EP_FILL     = 2'd0,
      EP_READY    = 2'd1,
      EP_XMIT     = 2'd2,
      EP_WAIT_ACK = 2'd3
   } ep_state_e;

   localparam logic PID_DATA0 = 1'b0;
   localparam logic PID_DATA1 = 1'b1;

endpackage

// File: rtl/usb_ep_byte_ram.sv
// Single-write, asynchronous-read byte array that holds one endpoint packet.
module usb_ep_byte_ram #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // No reset: contents are only meaningful below the committed byte count.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/usb_in_ep_pkt_buffer.sv
// Single-packet IN endpoint buffer: filled by the endpoint controller, drained by
// the protocol engine on IN tokens, with retransmit-until-ACK and DATA0/1 toggle.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// EP_FILL     | controller writes bytes; waits for done or a full packet
// EP_READY    | packet committed; next accepted IN token starts sending
// EP_XMIT     | engine pops bytes from rd_ptr
// EP_WAIT_ACK | packet sent; ACK completes it, a new IN token resends it
module usb_in_ep_pkt_buffer
   import usb_ep_pkg::*;
#(
   parameter int MAX_PKT_SIZE = 32,
   parameter int CNT_W        = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_ep_req,
   output logic       in_ep_grant,
   output logic       in_ep_data_free,
   input  logic       in_ep_data_put,
   input  logic [7:0] in_ep_data,
   input  logic       in_ep_data_done,
   input  logic       in_ep_stall,
   output logic       in_ep_acked,
   input  logic       in_xfr_start,
   output logic       in_xfr_ready,
   output logic       in_xfr_stall,
   output logic       in_xfr_data_avail,
   input  logic       in_xfr_data_get,
   output logic [7:0] in_xfr_data,
   input  logic       in_xfr_end,
   input  logic       in_xfr_acked,
   input  logic       setup_seen,
   output logic       data_toggle
);

   localparam int              AW      = $clog2(MAX_PKT_SIZE);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_SIZE);

   ep_state_e        state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_inc;
   logic             stalled;
   logic             wr_en;

   assign in_ep_grant       = in_ep_req && (state == EP_FILL);
   assign in_ep_data_free   = (state == EP_FILL) && (count < MAX_CNT);
   assign in_xfr_ready      = (state == EP_READY) && !stalled;
   assign in_xfr_stall      = stalled;
   assign in_xfr_data_avail = (state == EP_XMIT) && (rd_ptr < count);

   assign wr_en     = in_ep_data_put && in_ep_grant && in_ep_data_free;
   assign count_inc = count + CNT_W'(1);

   usb_ep_byte_ram #(
      .DEPTH (MAX_PKT_SIZE),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (count[AW-1:0]),
      .wdata (in_ep_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (in_xfr_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= EP_FILL;
         count       <= '0;
         rd_ptr      <= '0;
         stalled     <= 1'b0;
         data_toggle <= PID_DATA0;
         in_ep_acked <= 1'b0;
      end else if (setup_seen) begin
         // SETUP restarts the control transfer; its first IN data stage is DATA1.
         state       <= EP_FILL;
         count       <= '0;
         rd_ptr      <= '0;
         stalled     <= 1'b0;
         data_toggle <= PID_DATA1;
         in_ep_acked <= 1'b0;
      end else begin
         in_ep_acked <= 1'b0;
         if (in_ep_stall) stalled <= 1'b1;
         unique case (state)
            EP_FILL: begin
               if (wr_en) count <= count_inc;
               if (in_ep_data_done || (wr_en && count_inc == MAX_CNT))
                  state <= EP_READY;
            end
            EP_READY: begin
               if (in_xfr_start && !stalled) begin
                  state  <= EP_XMIT;
                  rd_ptr <= '0;
               end
            end
            EP_XMIT: begin
               if (in_xfr_data_get && in_xfr_data_avail) rd_ptr <= rd_ptr + CNT_W'(1);
               if (in_xfr_end) state <= EP_WAIT_ACK;
            end
            EP_WAIT_ACK: begin
               // ACK wins over a simultaneous IN token; that token was for the old packet.
               if (in_xfr_acked) begin
                  state       <= EP_FILL;
                  count       <= '0;
                  rd_ptr      <= '0;
                  data_toggle <= ~data_toggle;
                  in_ep_acked <= 1'b1;
               end else if (in_xfr_start && !stalled) begin
                  state  <= EP_XMIT;
                  rd_ptr <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_in_ep_pkt_buffer.sv
// Randomised bench for usb_in_ep_pkt_buffer with a queue-based packet model and
// a scoreboard that checks every byte the engine pops.
module tb_usb_in_ep_pkt_buffer;

   localparam int MAX = 32;
   localparam int S_FILL = 0, S_READY = 1, S_XMIT = 2, S_WAIT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_ep_req = 1'b0;
   logic       in_ep_grant, in_ep_data_free;
   logic       in_ep_data_put = 1'b0;
   logic [7:0] in_ep_data = 8'h00;
   logic       in_ep_data_done = 1'b0;
   logic       in_ep_stall = 1'b0;
   logic       in_ep_acked;
   logic       in_xfr_start = 1'b0;
   logic       in_xfr_ready, in_xfr_stall, in_xfr_data_avail;
   logic       in_xfr_data_get = 1'b0;
   logic [7:0] in_xfr_data;
   logic       in_xfr_end = 1'b0;
   logic       in_xfr_acked = 1'b0;
   logic       setup_seen = 1'b0;
   logic       data_toggle;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the packet is a byte queue plus a read index.
   int         m_st = S_FILL;
   logic [7:0] m_q[$];
   int         m_rd = 0;
   bit         m_tog = 0;
   bit         m_stall = 0;
   bit         m_ackp = 0;

   logic [7:0] exp_q[$];

   usb_in_ep_pkt_buffer #(.MAX_PKT_SIZE(MAX), .CNT_W(7)) dut (
      .clk               (clk),
      .reset             (reset),
      .in_ep_req         (in_ep_req),
      .in_ep_grant       (in_ep_grant),
      .in_ep_data_free   (in_ep_data_free),
      .in_ep_data_put    (in_ep_data_put),
      .in_ep_data        (in_ep_data),
      .in_ep_data_done   (in_ep_data_done),
      .in_ep_stall       (in_ep_stall),
      .in_ep_acked       (in_ep_acked),
      .in_xfr_start      (in_xfr_start),
      .in_xfr_ready      (in_xfr_ready),
      .in_xfr_stall      (in_xfr_stall),
      .in_xfr_data_avail (in_xfr_data_avail),
      .in_xfr_data_get   (in_xfr_data_get),
      .in_xfr_data       (in_xfr_data),
      .in_xfr_end        (in_xfr_end),
      .in_xfr_acked      (in_xfr_acked),
      .setup_seen        (setup_seen),
      .data_toggle       (data_toggle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_outputs();
      chk("grant",    8'(in_ep_grant),       8'(in_ep_req && m_st == S_FILL));
      chk("free",     8'(in_ep_data_free),   8'(m_st == S_FILL && m_q.size() < MAX));
      chk("ready",    8'(in_xfr_ready),      8'(m_st == S_READY && !m_stall));
      chk("stall",    8'(in_xfr_stall),      8'(m_stall));
      chk("avail",    8'(in_xfr_data_avail), 8'(m_st == S_XMIT && m_rd < m_q.size()));
      chk("toggle",   8'(data_toggle),       8'(m_tog));
      chk("ep_acked", 8'(in_ep_acked),       8'(m_ackp));
   endtask

   task automatic model_reset(input bit tog);
      m_st = S_FILL; m_q.delete(); m_rd = 0; m_stall = 0; m_tog = tog; m_ackp = 0;
   endtask

   task automatic model_step();
      int  n = m_q.size();
      bit  may_start = !m_stall;
      m_ackp = 0;
      if (setup_seen) begin
         model_reset(1'b1);
         return;
      end
      if (in_ep_stall) m_stall = 1;
      case (m_st)
         S_FILL: begin
            if (in_ep_data_put && in_ep_req && n < MAX) m_q.push_back(in_ep_data);
            if (in_ep_data_done || m_q.size() == MAX) m_st = S_READY;
         end
         S_READY: if (in_xfr_start && may_start) begin m_st = S_XMIT; m_rd = 0; end
         S_XMIT: begin
            if (in_xfr_data_get && m_rd < n) m_rd++;
            if (in_xfr_end) m_st = S_WAIT;
         end
         default: begin
            if (in_xfr_acked) begin
               m_st = S_FILL; m_q.delete(); m_rd = 0; m_tog = !m_tog; m_ackp = 1;
            end else if (in_xfr_start && may_start) begin
               m_st = S_XMIT; m_rd = 0;
            end
         end
      endcase
   endtask

   // Inputs are set just after a rising edge; outputs are checked on the falling edge.
   task automatic cycle();
      if (in_xfr_data_get && m_st == S_XMIT && m_rd < m_q.size()) exp_q.push_back(m_q[m_rd]);
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
      in_ep_data_put = 0; in_ep_data_done = 0; in_ep_stall = 0; in_xfr_start = 0;
      in_xfr_data_get = 0; in_xfr_end = 0; in_xfr_acked = 0; setup_seen = 0;
   endtask

   always @(negedge clk) begin
      if (reset && in_xfr_data_get && in_xfr_data_avail) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL data_unexpected at %0t: got %0h expected no byte", $time, in_xfr_data);
         end else begin
            chk("xfr_data", in_xfr_data, exp_q.pop_front());
         end
      end
   end

   task automatic put(input logic [7:0] b, input bit done);
      in_ep_req = 1; in_ep_data_put = 1; in_ep_data = b; in_ep_data_done = done;
      cycle();
   endtask

   task automatic fill(input int n, input bit done);
      for (int i = 0; i < n; i++) put(8'($urandom), done && (i == n - 1));
   endtask

   task automatic pulse_done(); in_ep_data_done = 1; cycle(); endtask
   task automatic pulse_start(); in_xfr_start = 1; cycle(); endtask
   task automatic pulse_end(); in_xfr_end = 1; cycle(); endtask
   task automatic pulse_ack(); in_xfr_acked = 1; cycle(); endtask
   task automatic idle(input int n); for (int i = 0; i < n; i++) cycle(); endtask

   task automatic pop(input int n);
      for (int i = 0; i < n; i++) begin
         in_xfr_data_get = 1; cycle();
         if ($urandom_range(3) == 0) cycle();
      end
   endtask

   task automatic async_reset();
      #2 reset = 0;
      #1;
      model_reset(1'b0);
      check_outputs();
      @(posedge clk); #1;
      reset = 1;
   endtask

   initial begin
      #3;
      model_reset(1'b0);
      check_outputs();
      @(posedge clk); #1;
      reset = 1;
      idle(2);

      // Packet of 18 bytes, full drain, ACK.
      put(8'h12, 0); put(8'h01, 0); fill(16, 0); pulse_done();
      pulse_start(); pop(18); idle(1); pulse_end(); idle(1); pulse_ack(); idle(3);

      // Overfill: auto-commit at MAX, extra puts dropped; next packet of 8.
      fill(40, 0); pulse_start(); pop(MAX); pulse_end(); pulse_ack(); idle(2);
      fill(8, 1); pulse_start(); pop(8); pulse_end(); pulse_ack(); idle(2);

      // Retransmit without ACK, then ACK.
      fill(11, 1); pulse_start(); pop(11); pulse_end(); idle(2);
      pulse_start(); pop(11); pulse_end(); pulse_ack(); idle(2);

      // Zero-length packet, with spurious gets.
      pulse_done(); idle(1); pulse_start(); pop(2); pulse_end(); pulse_ack(); idle(2);

      // Stall mid-fill, start ignored, SETUP clears.
      fill(5, 0); in_ep_stall = 1; cycle(); fill(3, 1); pulse_start(); pulse_start(); idle(2);
      setup_seen = 1; cycle(); idle(2);

      // Async reset during transmit at rd_ptr=5.
      fill(10, 1); pulse_start(); pop(5);
      async_reset(); idle(3);

      // ACK and IN token together: ACK wins.
      fill(6, 1); pulse_start(); pop(6); pulse_end();
      in_xfr_acked = 1; in_xfr_start = 1; cycle(); idle(3);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         in_ep_req       = ($urandom_range(7) != 0);
         in_ep_data_put  = $urandom_range(1);
         in_ep_data      = 8'($urandom);
         in_ep_data_done = ($urandom_range(19) == 0);
         in_ep_stall     = ($urandom_range(299) == 0);
         in_xfr_start    = ($urandom_range(5) == 0);
         in_xfr_data_get = $urandom_range(1);
         in_xfr_end      = ($urandom_range(14) == 0);
         in_xfr_acked    = ($urandom_range(5) == 0);
         setup_seen      = ($urandom_range(149) == 0);
         cycle();
      end
      idle(2);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d bytes left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/usb_in_ep_pkt_buffer.md
Name: usb_in_ep_pkt_buffer

Overview:
Single-packet IN endpoint buffer between an endpoint controller (e.g. the control endpoint) and the USB FS protocol engine. Accepts bytes over the in_ep_* put/done handshake, commits them as one packet, and serves them to the protocol engine on IN tokens. Retransmits on missing ACK and tracks the DATA0/DATA1 toggle. Handles STALL and SETUP flush.

Parameters:
MAX_PKT_SIZE, 32, packet buffer depth in bytes; legal 8, 16, 32, 64.
CNT_W, 7, width of byte counters; must satisfy 2**CNT_W > MAX_PKT_SIZE.

Ports:
clk  in  1  single clock domain, rising-edge.
reset  in  1  asynchronous, active-low: 0 = in reset.
in_ep_req  in  1  controller requests buffer access.
in_ep_grant  out  1  = in_ep_req && state==FILL.
in_ep_data_free  out  1  = state==FILL && count<MAX_PKT_SIZE.
in_ep_data_put  in  1  write in_ep_data this cycle.
in_ep_data  in  8  byte to write.
in_ep_data_done  in  1  commit current contents (may be zero-length).
in_ep_stall  in  1  pulse: stall the endpoint.
in_ep_acked  out  1  one-cycle pulse: host ACKed the committed packet.
in_xfr_start  in  1  pulse: IN token for this endpoint accepted by engine.
in_xfr_ready  out  1  = state==READY && !stalled; engine NAKs when 0.
in_xfr_stall  out  1  = stalled; engine answers STALL.
in_xfr_data_avail  out  1  = state==XMIT && rd_ptr<count.
in_xfr_data_get  in  1  pop one byte.
in_xfr_data  out  8  = buf[rd_ptr], combinational read.
in_xfr_end  in  1  pulse: engine finished sending the packet incl. CRC.
in_xfr_acked  in  1  pulse: ACK handshake received from host.
setup_seen  in  1  pulse: SETUP token received on paired OUT endpoint.
data_toggle  out  1  PID select: 0=DATA0, 1=DATA1.

Behaviour:
- Reset (reset=0, async): state=FILL, count=0, rd_ptr=0, stalled=0, data_toggle=0, in_ep_acked=0. All outputs derived from these.
- States: FILL, READY, XMIT, WAIT_ACK.
- FILL:
  - put && grant && data_free: buf[count]<=data, count++.
  - put while full or without grant: ignored, no overflow.
  - Transition to READY on data_done, or automatically when count reaches MAX_PKT_SIZE (full packet auto-commit).
  - put+done in the same cycle: byte is written and included in the packet.
  - done with count=0: zero-length packet committed.
  - in_xfr_start in FILL: ignored; in_xfr_ready=0 so the engine NAKs.
- READY: on in_xfr_start && !stalled, go to XMIT with rd_ptr=0. Puts are ignored.
- XMIT:
  - get && data_avail: rd_ptr++. get with avail=0 is ignored.
  - in_xfr_end -> WAIT_ACK, even if not all bytes were popped.
- WAIT_ACK:
  - in_xfr_acked -> FILL: count=0, rd_ptr=0, data_toggle flips, in_ep_acked pulses for 1 cycle (registered, the cycle after).
  - in_xfr_start without prior ack (host lost the data) -> XMIT with rd_ptr=0. Same data, same toggle.
  - acked and start in the same cycle: acked wins, start is dropped.
- Stall:
  - in_ep_stall sets stalled in any state.
  - While stalled: in_xfr_stall=1, in_xfr_ready=0, and in_xfr_start never enters XMIT.
  - State and data are kept.
- setup_seen (highest priority after reset, any state): state=FILL, count=0, rd_ptr=0, stalled=0, data_toggle=1, so the first IN packet after SETUP is DATA1.
- Latency: a committed packet is visible (in_xfr_ready=1) the cycle after done. The first byte is valid combinationally in the cycle XMIT is entered.
- Counters are CNT_W wide; count never exceeds MAX_PKT_SIZE and rd_ptr never exceeds count.

Decomposition:
- Shared package usb_ep_pkg holds the state encoding localparams (FILL/READY/XMIT/WAIT_ACK) and PID toggle constants, reused by the OUT buffer.
- One natural sub-module: usb_ep_byte_ram, a MAX_PKT_SIZE x 8 single-write, async-read array.
- Everything else stays in this block.

Test Plan:
1. Put 18 bytes 0x12,0x01,... then done; start; pop all bytes; end; acked -> bytes match in order, data_toggle 0->1, in_ep_acked pulses exactly 1 cycle.
2. Put 40 bytes with MAX=32 -> data_free drops after byte 32, auto-READY. After ACK the next 8 bytes plus done form packet 2 with toggle=1 before its ACK.
3. Retransmit: send packet, end, no ack, second start -> identical bytes from rd_ptr=0, same toggle. Then ack flips the toggle.
4. done with count=0 -> in_xfr_ready=1, data_avail=0 throughout XMIT; ack -> toggle flips.
5. in_ep_stall mid-FILL -> in_xfr_stall=1 and start is ignored. setup_seen -> stall clears, count=0, data_toggle=1.
6. Assert reset (0) during XMIT with rd_ptr=5 -> asynchronously FILL, count=0, toggle=0, no acked pulse. Simultaneous acked+start in WAIT_ACK -> FILL, start dropped.
